dac_spi_tx: RTL and testbench
=============================

# dac_spi_tx

- Serial DAC transmitter placed directly downstream of the waveform selector.
- Continuously samples the selected 16-bit DDS output and ships each sample to an external 24-bit-frame SPI DAC (8 control bits, then 16 data bits, MSB first).
- Generates SYNC_n, SCLK and DIN at a fixed, parameter-defined frame rate.
- Pulses a per-frame completion strobe.

## Interface
Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period (≥1)
- GAP_CYCLES, 3: clk cycles SYNC_n held high between frames (≥1)
- CTRL_BYTE, 8'h00: control byte sent in frame bits 23:16
- OFFSET_BINARY, 0: 1 = invert SampleIn[15] before sending (two's complement → offset binary)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- Enable  in  1  level; 1 = run frames back-to-back
- SampleIn  in  16  sample from waveform selector (SignalOut)
- DAC_SYNC_n  out  1  frame select, active low
- DAC_SCLK  out  1  serial clock, idles low
- DAC_DIN  out  1  serial data
- Busy  out  1  1 when state ≠ IDLE
- FrameDone  out  1  one-cycle pulse when a frame's last bit period ends

## Operation
- Reset values: DAC_SYNC_n=1, DAC_SCLK=0, DAC_DIN=0, Busy=0, FrameDone=0, state=IDLE. Shift register, bit counter and divider counter are all 0.
- FSM states: IDLE, SETUP, SHIFT, GAP.
- IDLE: when Enable=1, go to SETUP.
  - Capture frame = {CTRL_BYTE, data}, where data = OFFSET_BINARY ? {~SampleIn[15],SampleIn[14:0]} : SampleIn.
  - Drive SYNC_n=0, SCLK=0, DIN=frame[23].
- SETUP: exactly 1 cycle, then SHIFT.
- SHIFT: 24 bit periods, each 2*CLK_DIV cycles.
  - SCLK is 1 for the first CLK_DIV cycles of each period and 0 for the remaining CLK_DIV.
  - DIN changes only at the start of a bit period, coincident with the SCLK rise. It presents bits 23 down to 0.
  - The DAC samples on the SCLK falling edge.
  - After the low phase of bit 0, go to GAP: SYNC_n=1, SCLK=0, DIN=0, FrameDone=1 for that cycle.
- GAP: hold for GAP_CYCLES cycles, then:
  - if Enable=1, capture the next sample and go to SETUP directly (same actions as the IDLE exit);
  - otherwise go to IDLE.
- SampleIn is sampled only at frame capture. Changes during a frame are ignored.
- Enable deasserted mid-frame: the current frame completes normally; no new frame starts.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous). The partial frame is aborted. After release, the block starts from IDLE.
- Counters: bit counter 5 bits (0–23). Divider counter sized $clog2(2*CLK_DIV). Both are reset at frame capture.

## Timing
- Frame length = 1 + 48*CLK_DIV + GAP_CYCLES clk cycles. Defaults: 100 cycles, i.e. 500 kS/s at a 50 MHz clk.
- Latency from Enable rising (sampled at edge T0, in IDLE) to SYNC_n low: visible after edge T0, with DIN=bit 23 valid in the same cycle.
- First SCLK rise: 1 cycle after SYNC_n falls.
- SCLK falling edges relative to SYNC_n falling: at 1 + CLK_DIV + k*2*CLK_DIV cycles, for k = 0..23.
- DIN setup and hold around each SCLK falling edge: CLK_DIV cycles each.
- SYNC_n rises on the same edge as the last SCLK fall + CLK_DIV. FrameDone is high for that single cycle.
- Minimum SYNC_n high time: GAP_CYCLES cycles.
- Busy: rises with SYNC_n falling. Stays high through GAP. Falls on the GAP→IDLE transition.

## Structure
- Shared package dds_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, GAP);
  - DAC_FRAME_BITS=24;
  - DAC_DATA_BITS=16;
  - the default control byte constant.
- One natural sub-module: sclk_divider.
  - Counts 0..2*CLK_DIV-1 while enabled.
  - Outputs SCLK level, a bit_start pulse (period start) and a bit_end pulse (last cycle of period).
  - The FSM uses bit_end to advance the bit counter.
- The rest (FSM, shift register, output registers) stays in dac_spi_tx. All outputs are registered.

## Test plan
- Defaults, Enable=1, SampleIn=16'hA55A:
  - first frame shifts 24'h00A55A MSB first;
  - exactly 24 SCLK falling edges per SYNC_n-low window;
  - SYNC_n low for 97 cycles, high for 3;
  - FrameDone every 100 cycles.
- OFFSET_BINARY=1, SampleIn=16'h8000 then 16'h7FFF: data fields received are 16'h0000 then 16'hFFFF.
- SampleIn changed from 16'h1234 to 16'hFFFF at cycle 40 of a frame: the current frame carries 16'h1234; the next frame carries 16'hFFFF.
- Enable dropped at cycle 10 of a frame: frame completes with FrameDone; then Busy=0 and SYNC_n stays high with no further SCLK edges.
- reset asserted at cycle 50 of a frame: SYNC_n=1, SCLK=0, DIN=0 within the same cycle, with no clock edge needed. After release with Enable=1, a full, correct frame follows.
- CLK_DIV=1, GAP_CYCLES=1: frame length is 50 cycles; DIN stable 1 cycle either side of each SCLK fall.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS datapath and its serial DAC transmitter.
// Holds the DAC transmitter state encoding, frame geometry, the frame payload
// layout and the helper that assembles a frame from a sample.
package dds_pkg;

  localparam int unsigned DAC_FRAME_BITS = 24;
  localparam int unsigned DAC_DATA_BITS  = 16;
  localparam int unsigned DAC_CTRL_BITS  = DAC_FRAME_BITS - DAC_DATA_BITS;

  localparam logic [DAC_CTRL_BITS-1:0] DAC_CTRL_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } dacState_t;

  // One DAC frame, control byte in the top bits, sent MSB first.
  typedef struct packed {
    logic [DAC_CTRL_BITS-1:0] ctrl;
    logic [DAC_DATA_BITS-1:0] data;
  } dacFrame_t;

  // Flipping the sign bit maps two's complement onto offset binary.
  function automatic dacFrame_t buildFrame(
    input logic [DAC_CTRL_BITS-1:0] ctrl,
    input logic [DAC_DATA_BITS-1:0] sample,
    input logic                     offsetBinary
  );
    dacFrame_t f;
    f.ctrl = ctrl;
    f.data = sample;
    if (offsetBinary) begin
      f.data[DAC_DATA_BITS-1] = ~sample[DAC_DATA_BITS-1];
    end
    return f;
  endfunction

endpackage

// File: rtl/sclk_divider.sv
// SCLK bit-period timer for the DAC transmitter.
// Counts 0..2*CLK_DIV-1 while enabled and decodes the position of the
// current cycle inside a bit period.
//   clk, reset  : clock, async active-low reset
//   en          : count this cycle (frame is in its shift phase)
//   clr         : restart the period at frame capture
//   sclkLvl_c   : SCLK level belonging to the current cycle
//   bitStart_c  : current cycle is the first of a bit period
//   bitEnd_c    : current cycle is the last of a bit period
//   sclkFall_c  : current cycle is the last high cycle (SCLK falls after it)
module sclk_divider #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic sclkLvl_c,
  output logic bitStart_c,
  output logic bitEnd_c,
  output logic sclkFall_c
);

  localparam int unsigned PERIOD = 2 * CLK_DIV;
  localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] divCnt;

  // Period position counter, wraps at the end of each bit period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divCnt <= '0;
    end else if (clr) begin
      divCnt <= '0;
    end else if (en) begin
      divCnt <= bitEnd_c ? '0 : divCnt + CNT_W'(1);
    end
  end

  assign sclkLvl_c  = (divCnt < CNT_W'(CLK_DIV));
  assign bitStart_c = (divCnt == '0);
  assign bitEnd_c   = (divCnt == CNT_W'(PERIOD - 1));
  assign sclkFall_c = (divCnt == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/dac_spi_tx.sv
// Serial transmitter for a 24-bit-frame SPI DAC fed by the waveform selector.
// Captures SampleIn at each frame start and shifts {CTRL_BYTE, data} out MSB
// first; frames run back-to-back while Enable is high.
//   clk, reset  : clock, async active-low reset
//   Enable      : level, keep starting frames while high
//   SampleIn    : 16-bit sample, captured only at frame start
//   DAC_SYNC_n  : frame select, low for the whole 24-bit frame
//   DAC_SCLK    : serial clock, idles low, DAC samples on falling edge
//   DAC_DIN     : serial data, changes together with the SCLK rise
//   Busy        : high whenever a frame or its trailing gap is in progress
//   FrameDone   : one-cycle pulse as SYNC_n returns high
module dac_spi_tx
  import dds_pkg::*;
#(
  parameter int unsigned                CLK_DIV       = 2,
  parameter int unsigned                GAP_CYCLES    = 3,
  parameter logic [DAC_CTRL_BITS-1:0]   CTRL_BYTE     = DAC_CTRL_DEFAULT,
  parameter bit                         OFFSET_BINARY = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Enable,
  input  logic [DAC_DATA_BITS-1:0] SampleIn,
  output logic                     DAC_SYNC_n,
  output logic                     DAC_SCLK,
  output logic                     DAC_DIN,
  output logic                     Busy,
  output logic                     FrameDone
);

  localparam int unsigned BIT_W    = 5;
  localparam int unsigned LAST_BIT = DAC_FRAME_BITS - 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  dacState_t                 state, stateNxt;
  logic [DAC_FRAME_BITS-1:0] shiftReg, shiftNxt;
  logic [BIT_W-1:0]          bitCnt, bitCntNxt;
  logic [GAP_W-1:0]          gapCnt, gapCntNxt;
  logic                      syncNxt, sclkNxt, dinNxt, busyNxt, doneNxt;

  logic                      capture_c;
  logic                      shiftActive_c;
  dacFrame_t                 newFrame_c;
  logic                      sclkLvl_c, bitStart_c, bitEnd_c, sclkFall_c;

  assign newFrame_c    = buildFrame(CTRL_BYTE, SampleIn, OFFSET_BINARY);
  assign shiftActive_c = (state == SHIFT);

  sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_sclkDivider (
    .clk        (clk),
    .reset      (reset),
    .en         (shiftActive_c),
    .clr        (capture_c),
    .sclkLvl_c  (sclkLvl_c),
    .bitStart_c (bitStart_c),
    .bitEnd_c   (bitEnd_c),
    .sclkFall_c (sclkFall_c)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      bitCnt     <= '0;
      gapCnt     <= '0;
      DAC_SYNC_n <= 1'b1;
      DAC_SCLK   <= 1'b0;
      DAC_DIN    <= 1'b0;
      Busy       <= 1'b0;
      FrameDone  <= 1'b0;
    end else begin
      state      <= stateNxt;
      shiftReg   <= shiftNxt;
      bitCnt     <= bitCntNxt;
      gapCnt     <= gapCntNxt;
      DAC_SYNC_n <= syncNxt;
      DAC_SCLK   <= sclkNxt;
      DAC_DIN    <= dinNxt;
      Busy       <= busyNxt;
      FrameDone  <= doneNxt;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every pin comes straight from a flop.
  always_comb begin
    stateNxt  = state;
    shiftNxt  = shiftReg;
    bitCntNxt = bitCnt;
    gapCntNxt = gapCnt;
    syncNxt   = DAC_SYNC_n;
    sclkNxt   = DAC_SCLK;
    dinNxt    = DAC_DIN;
    doneNxt   = 1'b0;
    capture_c = 1'b0;

    case (state)
      IDLE: begin
        capture_c = Enable;
      end

      SETUP: begin
        stateNxt = SHIFT;
        sclkNxt  = 1'b1;
      end

      SHIFT: begin
        // Advance early in the period so the next bit sits at the MSB by the end.
        if (bitStart_c) begin
          shiftNxt = {shiftReg[DAC_FRAME_BITS-2:0], 1'b0};
        end
        sclkNxt = sclkFall_c ? 1'b0 : sclkLvl_c;
        if (bitEnd_c) begin
          if (bitCnt == BIT_W'(LAST_BIT)) begin
            stateNxt  = GAP;
            gapCntNxt = '0;
            syncNxt   = 1'b1;
            sclkNxt   = 1'b0;
            dinNxt    = 1'b0;
            doneNxt   = 1'b1;
          end else begin
            bitCntNxt = bitCnt + BIT_W'(1);
            sclkNxt   = 1'b1;
            dinNxt    = shiftReg[DAC_FRAME_BITS-1];
          end
        end
      end

      GAP: begin
        if (gapCnt == GAP_W'(GAP_CYCLES - 1)) begin
          if (Enable) begin
            capture_c = 1'b1;
          end else begin
            stateNxt = IDLE;
          end
        end else begin
          gapCntNxt = gapCnt + GAP_W'(1);
        end
      end

      default: begin
        stateNxt = IDLE;
      end
    endcase

    // Frame capture: shared by the IDLE exit and the back-to-back GAP exit.
    if (capture_c) begin
      stateNxt  = SETUP;
      shiftNxt  = newFrame_c;
      bitCntNxt = '0;
      syncNxt   = 1'b0;
      sclkNxt   = 1'b0;
      dinNxt    = newFrame_c[DAC_FRAME_BITS-1];
    end

    busyNxt = (stateNxt != IDLE);
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances (defaults, offset binary with a custom
// control byte, fastest SCLK with the shortest gap) driven with directed and
// random samples/enables. A frame-position reference model predicts each
// frame's pins and pushes the expected 24-bit word on capture; a negedge
// monitor decodes the serial stream and checks it against the queue.
module tb_dac_spi_tx;

  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        rstN;
  logic [2:0]  en;
  logic [15:0] smp0, smp1, smp2;
  wire  [2:0]  syncN, sclk, din, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  dac_spi_tx dut0 (
    .clk(clk), .reset(rstN), .Enable(en[0]), .SampleIn(smp0),
    .DAC_SYNC_n(syncN[0]), .DAC_SCLK(sclk[0]), .DAC_DIN(din[0]),
    .Busy(busy[0]), .FrameDone(done[0])
  );

  dac_spi_tx #(.CLK_DIV(2), .GAP_CYCLES(3), .CTRL_BYTE(8'hA7), .OFFSET_BINARY(1'b1)) dut1 (
    .clk(clk), .reset(rstN), .Enable(en[1]), .SampleIn(smp1),
    .DAC_SYNC_n(syncN[1]), .DAC_SCLK(sclk[1]), .DAC_DIN(din[1]),
    .Busy(busy[1]), .FrameDone(done[1])
  );

  dac_spi_tx #(.CLK_DIV(1), .GAP_CYCLES(1), .CTRL_BYTE(8'h5C), .OFFSET_BINARY(1'b0)) dut2 (
    .clk(clk), .reset(rstN), .Enable(en[2]), .SampleIn(smp2),
    .DAC_SYNC_n(syncN[2]), .DAC_SCLK(sclk[2]), .DAC_DIN(din[2]),
    .Busy(busy[2]), .FrameDone(done[2])
  );

  // Per-channel configuration.
  function automatic int cdOf(input int c);
    return (c == 2) ? 1 : 2;
  endfunction
  function automatic int gapOf(input int c);
    return (c == 2) ? 1 : 3;
  endfunction
  function automatic logic [7:0] ctrlOf(input int c);
    case (c)
      1:       return 8'hA7;
      2:       return 8'h5C;
      default: return 8'h00;
    endcase
  endfunction
  function automatic int lowOf(input int c);
    return 1 + 48 * cdOf(c);
  endfunction
  function automatic int periodOf(input int c);
    return lowOf(c) + gapOf(c);
  endfunction
  function automatic logic [15:0] smpOf(input int c);
    case (c)
      1:       return smp1;
      2:       return smp2;
      default: return smp0;
    endcase
  endfunction

  // Expected wire word: offset binary adds half scale modulo 2^16.
  function automatic logic [23:0] refFrame(input int c, input logic [15:0] s);
    logic [15:0] d;
    d = (c == 1) ? s + 16'h8000 : s;
    return {ctrlOf(c), d};
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d actual=%0h required=%0h t=%0t", name, c, act, exp, $time);
    end
  endtask

  // Scoreboard queues.
  logic [23:0] q0[$], q1[$], q2[$];

  task automatic pushExp(input int c, input logic [23:0] v);
    case (c)
      1:       q1.push_back(v);
      2:       q2.push_back(v);
      default: q0.push_back(v);
    endcase
  endtask

  task automatic popExp(input int c, output logic [23:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    case (c)
      1:       if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
      2:       if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
      default: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int qSize(input int c);
    case (c)
      1:       return q1.size();
      2:       return q2.size();
      default: return q0.size();
    endcase
  endfunction

  // Reference model: position within the current frame (-1 = idle).
  int          mPos[NCH] = '{-1, -1, -1};
  logic [23:0] mFrame[NCH];

  initial begin
    forever begin
      @(posedge clk or negedge rstN);
      if (rstN !== 1'b1) begin
        for (int c = 0; c < NCH; c++) begin
          mPos[c]   = -1;
          mFrame[c] = '0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (mPos[c] >= 0) mPos[c] = mPos[c] + 1;
          if (mPos[c] >= periodOf(c)) mPos[c] = -1;
          if (mPos[c] == -1 && en[c] == 1'b1) begin
            mPos[c]   = 0;
            mFrame[c] = refFrame(c, smpOf(c));
            pushExp(c, mFrame[c]);
          end
        end
      end
    end
  end

  // Monitor state.
  int          lowLen[NCH], highLen[NCH], nBits[NCH], lastDone[NCH];
  bit          contig[NCH];
  logic [23:0] rx[NCH];
  logic        pSync[NCH], pSclk[NCH], pDin[NCH];

  task automatic monitorCh(input int c);
    logic        s, k, d, b, fd;
    logic [4:0]  expV;
    logic [23:0] e;
    bit          ok;
    int          p, cd;
    s = syncN[c]; k = sclk[c]; d = din[c]; b = busy[c]; fd = done[c];
    if (rstN !== 1'b1) begin
      lowLen[c] = 0; highLen[c] = 0; nBits[c] = 0; rx[c] = '0;
      pSync[c] = 1'b1; pSclk[c] = 1'b0; pDin[c] = 1'b0;
      lastDone[c] = -1; contig[c] = 1'b0;
      return;
    end
    p  = mPos[c];
    cd = cdOf(c);

    // Cycle-level pin prediction {sync, sclk, din, busy, done}.
    expV = 5'b10000;
    if (p >= 0) begin
      expV[1] = 1'b1;
      if (p < lowOf(c)) begin
        expV[4] = 1'b0;
        if (p == 0) begin
          expV[2] = mFrame[c][23];
        end else begin
          expV[3] = (((p - 1) % (2 * cd)) < cd);
          expV[2] = mFrame[c][23 - (p - 1) / (2 * cd)];
        end
      end else begin
        expV[0] = (p == lowOf(c));
      end
    end
    chk("pins", c, 32'({s, k, d, b, fd}), 32'(expV));

    // Frame-level decoding as the DAC would see it.
    if (pSync[c] && !s) begin
      if (lastDone[c] >= 0) chk("gapMin", c, 32'(highLen[c] >= gapOf(c)), 32'd1);
      lowLen[c] = 0;
      nBits[c]  = 0;
      rx[c]     = '0;
    end
    if (!s && pSclk[c] && !k) begin
      chk("fallPos", c, lowLen[c], 1 + cd + 2 * nBits[c] * cd);
      rx[c]    = {rx[c][22:0], pDin[c]};
      nBits[c] = nBits[c] + 1;
    end
    if (!s && !pSync[c] && (d != pDin[c])) begin
      chk("dinEdge", c, 32'({pSclk[c], k}), 32'd1);
    end
    if (!pSync[c] && s) begin
      chk("bitCount", c, nBits[c], 24);
      chk("syncLow", c, lowLen[c], lowOf(c));
      popExp(c, e, ok);
      if (!ok) chk("frameQueued", c, 0, 1);
      else     chk("frame", c, 32'(rx[c]), 32'(e));
      highLen[c] = 0;
    end
    if (fd) begin
      chk("doneAtSyncRise", c, 32'({pSync[c], s}), 32'd1);
      if (lastDone[c] >= 0 && contig[c]) chk("framePeriod", c, cyc - lastDone[c], periodOf(c));
      lastDone[c] = cyc;
      contig[c]   = 1'b1;
    end
    if (!b) contig[c] = 1'b0;
    if (!s) lowLen[c] = lowLen[c] + 1;
    else    highLen[c] = highLen[c] + 1;
    pSync[c] = s;
    pSclk[c] = k;
    pDin[c]  = d;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NCH; c++) monitorCh(c);
    end
  end

  task automatic waitSyncLow(input int c, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (syncN[c] == 1'b0) found = 1'b1;
    end
    if (!found) chk("syncLowTimeout", c, 0, 1);
  endtask

  task automatic waitDone(input int c, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done[c] == 1'b1) found = 1'b1;
    end
    if (!found) chk("doneTimeout", c, 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b1;
    en   = '0;
    smp0 = '0; smp1 = '0; smp2 = '0;
    #1 rstN = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++)
      chk("resetOut", c, 32'({syncN[c], sclk[c], din[c], busy[c], done[c]}), 32'h10);
    repeat (3) @(negedge clk);
    rstN = 1'b1;

    // Directed: A55A stream, offset-binary extremes, mid-frame sample change.
    smp0 = 16'hA55A;
    smp1 = 16'h8000;
    smp2 = 16'h1234;
    en   = 3'b111;
    repeat (40) @(negedge clk);
    smp2 = 16'hFFFF;
    repeat (10) @(negedge clk);
    smp1 = 16'h7FFF;
    repeat (200) @(negedge clk);

    // Random samples every cycle with occasional enable toggles.
    repeat (2500) begin
      @(negedge clk);
      smp0 = 16'($urandom);
      smp1 = 16'($urandom);
      smp2 = 16'($urandom);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 199) == 0) en[c] = ~en[c];
    end

    // Enable dropped ten cycles into a frame.
    en = '0;
    repeat (250) @(negedge clk);
    smp0  = 16'h0F0F;
    en[0] = 1'b1;
    waitSyncLow(0, 300);
    repeat (10) @(negedge clk);
    en[0] = 1'b0;
    smp0  = 16'hFFFF;
    waitDone(0, 200);
    repeat (5) @(negedge clk);
    chk("busyAfterDrop", 0, 32'(busy[0]), 32'd0);
    chk("syncAfterDrop", 0, 32'(syncN[0]), 32'd1);
    repeat (150) @(negedge clk);

    // Asynchronous reset fifty cycles into a frame.
    smp0 = 16'hC3A5;
    en   = 3'b111;
    waitSyncLow(0, 300);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++)
      chk("asyncReset", c, 32'({syncN[c], sclk[c], din[c], busy[c], done[c]}), 32'h10);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (300) @(negedge clk);

    // Drain and confirm every expected frame was delivered.
    en = '0;
    repeat (250) @(negedge clk);
    for (int c = 0; c < NCH; c++) chk("drained", c, qSize(c), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
